instr_encode_loader: RTL and testbench

Sequential inverse of the decode-stage control unit. Accepts symbolic instruction commands (operation, register fields, immediate) over a valid/ready handshake. Encodes each command into a 32-bit MIPS word and writes it to instruction memory at consecutive word addresses. Used by the testbench/boot path to load programs into the pipelined core's instruction memory before the core is released.

---
 rtl/instr_encode_loader_pkg.sv | 59 +++++
 rtl/instr_field_encoder.sv | 42 ++++
 rtl/instr_encode_loader.sv | 135 +++++++++++++
 tb/tb_instr_encode_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_encode_loader_pkg.sv
// Shared encoding package for the instruction loader and the decode-stage
// control unit.
//
// Contents:
//   - cmd_op codes accepted by the loader (9..15 are illegal)
//   - MIPS primary opcodes and R-type funct codes
//   - loader FSM state encoding
//   - helpers that assemble R-type and I-type instruction words
package instr_encode_loader_pkg;

  // Symbolic command operations.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;

  // MIPS primary opcodes.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  // R-type funct codes.
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // {opcode, rs, rt, rd, shamt, funct}; shamt is always zero here.
  function automatic logic [31:0] r_word(input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'b0, funct};
  endfunction

  // {opcode, rs, rt, imm}.
  function automatic logic [31:0] i_word(input logic [5:0]  opcode,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: symbolic command -> 32-bit MIPS word.
//
// Ports:
//   cmd_op  in  4   command operation (see package OP_* codes)
//   rs      in  5   rs field
//   rt      in  5   rt field
//   rd      in  5   rd field (R-type only)
//   imm     in  16  immediate (I-type only)
//   word    out 32  encoded instruction (0 when illegal)
//   legal   out 1   cmd_op is one of the nine supported operations
module instr_field_encoder
  import instr_encode_loader_pkg::*;
(
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned (that would infer a latch).
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (cmd_op)
      OP_ADD:  word = r_word(rs, rt, rd, FUNCT_ADD);
      OP_SUB:  word = r_word(rs, rt, rd, FUNCT_SUB);
      OP_AND:  word = r_word(rs, rt, rd, FUNCT_AND);
      OP_OR:   word = r_word(rs, rt, rd, FUNCT_OR);
      OP_SLT:  word = r_word(rs, rt, rd, FUNCT_SLT);
      OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
      OP_LW:   word = i_word(OPC_LW,   rs, rt, imm);
      OP_SW:   word = i_word(OPC_SW,   rs, rt, imm);
      OP_BEQ:  word = i_word(OPC_BEQ,  rs, rt, imm);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction-memory loader: accepts symbolic commands over valid/ready,
// encodes each into a MIPS word and writes it to consecutive word addresses
// starting at BASE_ADDR. Writes issue one cycle after acceptance.
//
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   start           one-cycle pulse; opens a session from IDLE or DONE
//   cmd_valid/ready command handshake (ready only while loading)
//   cmd_op/rs/rt/rd/imm/last  command fields
//   imem_we/addr/wdata        one-cycle instruction-memory write port
//   busy / done     session in progress / session finished
//   overflow        session ended because the address space ran out
//   illegal_err     sticky; an illegal cmd_op was consumed this session
//   word_count      words written this session
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              illegal_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              accept_write;
  logic              at_end;
  logic              start_session;

  instr_field_encoder u_encoder (
    .cmd_op (cmd_op),
    .rs     (cmd_rs),
    .rt     (cmd_rt),
    .rd     (cmd_rd),
    .imm    (cmd_imm),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  assign accept        = cmd_valid & cmd_ready;
  assign accept_write  = accept & enc_legal;
  assign at_end        = (addr_q == LAST_ADDR);
  // start is only honoured outside LOAD.
  assign start_session = start & (state_q != ST_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cmd_ready = 1'b1;
        busy      = 1'b1;
        // A legal write to the last address closes the session even without
        // cmd_last, so ready is already low during that write.
        if (accept && (cmd_last || (enc_legal && at_end))) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= BASE;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      overflow    <= 1'b0;
      illegal_err <= 1'b0;
      word_count  <= '0;
    end else begin
      imem_we <= accept_write;
      if (accept_write) begin
        imem_addr  <= addr_q;
        imem_wdata <= enc_word;
      end

      if (start_session) begin
        addr_q      <= BASE;
        overflow    <= 1'b0;
        illegal_err <= 1'b0;
        word_count  <= '0;
      end else if (accept) begin
        if (enc_legal) begin
          word_count <= word_count + (ADDR_W+1)'(1);
          // The address saturates at the top rather than wrapping.
          if (!at_end)       addr_q   <= addr_q + ADDR_W'(1);
          else if (!cmd_last) overflow <= 1'b1;
        end else begin
          illegal_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader: a default instance
// (ADDR_W=8, BASE_ADDR=0) and a small instance (ADDR_W=2, BASE_ADDR=2) that
// exercises address-space overflow.
module tb_instr_encode_loader;

  localparam logic [3:0] ADD = 4'd0, OR_ = 4'd3, ADDI = 4'd5, LW = 4'd6,
                         SW = 4'd7, BEQ = 4'd8, BAD = 4'd12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance.
  logic        start, cmd_valid, cmd_ready, cmd_last;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm;
  logic        imem_we, busy, done, overflow, illegal_err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  // Small instance.
  logic        s_start, s_valid, s_ready;
  logic [15:0] s_imm;
  logic        s_we, s_busy, s_done, s_overflow, s_illegal;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  instr_encode_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .overflow(overflow),
    .illegal_err(illegal_err), .word_count(word_count)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(2)) dut_small (
    .clk(clk), .reset(reset), .start(s_start),
    .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_op(ADDI),
    .cmd_rs(5'd0), .cmd_rt(5'd1), .cmd_rd(5'd0), .cmd_imm(s_imm),
    .cmd_last(1'b0), .imem_we(s_we), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .busy(s_busy), .done(s_done),
    .overflow(s_overflow), .illegal_err(s_illegal), .word_count(s_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a command, let it be accepted, then check the write it produces.
  task automatic send(input string tag, input logic [3:0] op,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm,
                      input logic last, input logic [7:0] exp_addr,
                      input logic [31:0] exp_word);
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm = imm; cmd_last = last;
    tick();
    check({tag, ".we"},    32'(imem_we),    32'd1);
    check({tag, ".addr"},  32'(imem_addr),  32'(exp_addr));
    check({tag, ".wdata"}, imem_wdata,      exp_word);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_op = ADD;
    cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_imm = '0; cmd_last = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_imm = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    check("rst.we",    32'(imem_we),    32'd0);
    check("rst.ready", 32'(cmd_ready),  32'd0);
    check("rst.busy",  32'(busy),       32'd0);
    check("rst.done",  32'(done),       32'd0);
    check("rst.count", 32'(word_count), 32'd0);
    check("rst.addr",  32'(imem_addr),  32'd0);

    // 1: single ADD with last.
    pulse_start();
    check("t1.busy",  32'(busy),      32'd1);
    check("t1.ready", 32'(cmd_ready), 32'd1);
    send("t1.add", ADD, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 8'd0, 32'h00221820);
    cmd_valid = 1'b0;
    tick();
    check("t1.we_off", 32'(imem_we),    32'd0);
    check("t1.done",   32'(done),       32'd1);
    check("t1.count",  32'(word_count), 32'd1);

    // 2: back-to-back stream; trailing ADDI must not be taken in DONE.
    pulse_start();
    send("t2.lw",  LW,  5'd0,  5'd8,  5'd0, 16'h0004, 1'b0, 8'd0, 32'h8C080004);
    send("t2.sw",  SW,  5'd29, 5'd31, 5'd0, 16'h0008, 1'b0, 8'd1, 32'hAFBF0008);
    send("t2.beq", BEQ, 5'd4,  5'd5,  5'd0, 16'hFFFF, 1'b1, 8'd2, 32'h1085FFFF);
    check("t2.ready_done", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_op = ADDI; cmd_rs = 5'd0; cmd_rt = 5'd1;
    cmd_imm = 16'd5; cmd_last = 1'b0;
    tick();
    check("t2.addi_we", 32'(imem_we), 32'd0);
    tick();
    check("t2.addi_we2", 32'(imem_we),    32'd0);
    check("t2.count",    32'(word_count), 32'd3);
    check("t2.done",     32'(done),       32'd1);
    cmd_valid = 1'b0;

    // 3: small instance runs out of addresses after two writes.
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_valid = 1'b1; s_imm = 16'd5;
    tick();
    check("t3.we0",    32'(s_we),    32'd1);
    check("t3.addr0",  32'(s_addr),  32'd2);
    check("t3.wdata0", s_wdata,      32'h20010005);
    s_imm = 16'd6;
    tick();
    check("t3.we1",    32'(s_we),       32'd1);
    check("t3.addr1",  32'(s_addr),     32'd3);
    check("t3.wdata1", s_wdata,         32'h20010006);
    check("t3.ready",  32'(s_ready),    32'd0);
    check("t3.ovf_w",  32'(s_overflow), 32'd1);
    s_imm = 16'd7;
    tick();
    check("t3.stall",  32'(s_we),       32'd0);
    check("t3.done",   32'(s_done),     32'd1);
    check("t3.ovf",    32'(s_overflow), 32'd1);
    check("t3.count",  32'(s_count),    32'd2);
    check("t3.addr_h", 32'(s_addr),     32'd3);
    s_valid = 1'b0;

    // 4: illegal op between two ADDs is consumed without a write.
    pulse_start();
    check("t4.ill_clr", 32'(illegal_err), 32'd0);
    send("t4.add0", ADD, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 8'd0, 32'h00221820);
    cmd_op = BAD; cmd_last = 1'b0;
    tick();
    check("t4.ill_we", 32'(imem_we),     32'd0);
    check("t4.ill",    32'(illegal_err), 32'd1);
    send("t4.add1", ADD, 5'd4, 5'd5, 5'd6, 16'h0, 1'b1, 8'd1, 32'h00853020);
    cmd_valid = 1'b0;
    tick();
    check("t4.count",  32'(word_count),  32'd2);
    check("t4.ill_st", 32'(illegal_err), 32'd1);
    check("t4.done",   32'(done),        32'd1);

    // 5: reset during a write cycle.
    pulse_start();
    send("t5.add", ADD, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 8'd0, 32'h00221820);
    cmd_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("t5.we",    32'(imem_we),     32'd0);
    check("t5.busy",  32'(busy),        32'd0);
    check("t5.ready", 32'(cmd_ready),   32'd0);
    check("t5.count", 32'(word_count),  32'd0);
    check("t5.wdata", imem_wdata,       32'd0);
    check("t5.ill",   32'(illegal_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t5.we_hold", 32'(imem_we), 32'd0);
    pulse_start();
    send("t5.restart", ADD, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 8'd0, 32'h00221820);
    cmd_valid = 1'b0;
    tick();
    check("t5.done", 32'(done), 32'd1);

    // 6: restart from DONE with the command already valid.
    cmd_valid = 1'b1; cmd_op = OR_; cmd_rs = 5'd5; cmd_rt = 5'd6;
    cmd_rd = 5'd7; cmd_last = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t6.count_clr", 32'(word_count), 32'd0);
    check("t6.busy",      32'(busy),       32'd1);
    check("t6.we_start",  32'(imem_we),    32'd0);
    send("t6.or", OR_, 5'd5, 5'd6, 5'd7, 16'h0, 1'b1, 8'd0, 32'h00A63825);
    check("t6.count", 32'(word_count), 32'd1);
    cmd_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
